// File: rtl/tetris_input_if.sv
// Button / command bundle between the raw input pins and the piece controller.
// Optional hard-drop signals appear when TETRIS_INPUT_HARD_DROP_EN is defined.
interface tetris_input_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_down;
    logic       btn_rotate;
    logic [3:0] level;
    logic       pause;
    logic       move_left;
    logic       move_right;
    logic       move_down;
    logic       rotate;
    logic       tick;
`ifdef TETRIS_INPUT_HARD_DROP_EN
    logic       btn_drop;
    logic       hard_drop;
`endif

    // board / stimulus side: drives buttons, level and pause
    modport master (
        output btn_left, btn_right, btn_down, btn_rotate, level, pause,
        input  move_left, move_right, move_down, rotate, tick
`ifdef TETRIS_INPUT_HARD_DROP_EN
        , output btn_drop
        , input  hard_drop
`endif
    );

    // input controller side: consumes buttons, produces command pulses
    modport slave (
        input  btn_left, btn_right, btn_down, btn_rotate, level, pause,
        output move_left, move_right, move_down, rotate, tick
`ifdef TETRIS_INPUT_HARD_DROP_EN
        , input  btn_drop
        , output hard_drop
`endif
    );
endinterface

// File: rtl/tetris_input_ctrl.sv
// Tetris input controller: button sync/debounce, press edges, DAS/ARR
// auto-repeat, left+right cancel, pause and level-dependent gravity tick.
// Define TETRIS_INPUT_HARD_DROP_EN to add the btn_drop -> hard_drop lane.

// One button lane: 2-FF synchronizer followed by a stability-count debouncer.
module tetris_btn_db #(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic deb
);
    localparam logic [23:0] DB_LAST = 24'(DB_CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic [23:0] cnt;

    // bring the asynchronous pin into the clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // accept a new level only after it has differed for DB_CYCLES cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (sync2 == deb) begin
            cnt <= '0;
        end else if (cnt == DB_LAST) begin
            cnt <= '0;
            deb <= sync2;
        end else begin
            cnt <= cnt + 24'd1;
        end
    end
endmodule

// Auto-repeat for one direction: first pulse on press, next after DAS,
// then every ARR while held. hold forces IDLE (pause or left+right cancel).
module tetris_btn_rpt #(
    parameter int unsigned DAS_CYCLES = 4000000,
    parameter int unsigned ARR_CYCLES = 1250000
) (
    input  logic clk,
    input  logic reset,
    input  logic deb,
    input  logic press,
    input  logic hold,
    output logic fire
);
    localparam logic [23:0] DAS_LAST = 24'(DAS_CYCLES - 1);
    localparam logic [23:0] ARR_LAST = 24'(ARR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

    rpt_state_e  state, state_next;
    logic [23:0] cnt, cnt_next;

    // state and interval counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // release or hold drops straight back to IDLE without a pulse
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fire       = 1'b0;
        if (hold || !deb) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        fire       = 1'b1;
                        state_next = DELAY;
                        cnt_next   = '0;
                    end
                end
                DELAY: begin
                    if (cnt == DAS_LAST) begin
                        fire       = 1'b1;
                        state_next = REPEAT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 24'd1;
                    end
                end
                REPEAT: begin
                    if (cnt == ARR_LAST) begin
                        fire     = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt + 24'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end
endmodule

module tetris_input_ctrl #(
    parameter int unsigned DB_CYCLES  = 250000,
    parameter int unsigned DAS_CYCLES = 4000000,
    parameter int unsigned ARR_CYCLES = 1250000,
    parameter int unsigned TICK_BASE  = 12500000,
    parameter int unsigned TICK_STEP  = 1000000,
    parameter int unsigned TICK_MIN   = 1250000
) (
    input  logic          clk,
    input  logic          reset,
    tetris_input_if.slave bus
);
`ifdef TETRIS_INPUT_HARD_DROP_EN
    localparam int NUM_BTN = 5;
`else
    localparam int NUM_BTN = 4;
`endif
    // lanes 0..2 auto-repeat; lanes from 3 up are one-shot
    localparam int NUM_RPT = 3;
    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_DOWN  = 2;
    localparam int B_ROT   = 3;

    localparam logic [27:0] BASE_W = 28'(TICK_BASE);
    localparam logic [27:0] STEP_W = 28'(TICK_STEP);
    localparam logic [27:0] MIN_W  = 28'(TICK_MIN);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] deb;
    logic [NUM_BTN-1:0] deb_q;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] fire;
    logic [NUM_BTN-1:0] cmd_q;
    logic [NUM_RPT-1:0] rpt_hold;
    logic [NUM_RPT-1:0] rpt_fire;
    logic               lr_cancel;
    logic               grav_clr;
    logic [27:0]        level_prod;
    logic [27:0]        period_raw;
    logic [27:0]        period;
    logic [23:0]        grav_cnt;
    logic               tick_q;

`ifdef TETRIS_INPUT_HARD_DROP_EN
    assign btn_raw = {bus.btn_drop, bus.btn_rotate, bus.btn_down, bus.btn_right, bus.btn_left};
`else
    assign btn_raw = {bus.btn_rotate, bus.btn_down, bus.btn_right, bus.btn_left};
`endif

    tetris_btn_db #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_BTN-1:0] (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_raw),
        .deb   (deb)
    );

    // previous debounced state; a 0->1 step is a press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) deb_q <= '0;
        else        deb_q <= deb;
    end

    assign press     = deb & ~deb_q;
    // both sideways buttons held: neither moves, and the surviving press is spent
    assign lr_cancel = deb[B_LEFT] & deb[B_RIGHT];
    assign rpt_hold  = {bus.pause, {2{bus.pause | lr_cancel}}};

    tetris_btn_rpt #(.DAS_CYCLES(DAS_CYCLES), .ARR_CYCLES(ARR_CYCLES)) u_rpt [NUM_RPT-1:0] (
        .clk   (clk),
        .reset (reset),
        .deb   (deb[NUM_RPT-1:0]),
        .press (press[NUM_RPT-1:0]),
        .hold  (rpt_hold),
        .fire  (rpt_fire)
    );

    // merge repeat lanes with one-shot lanes; pause silences everything
    always_comb begin
        fire = '0;
        fire[NUM_RPT-1:0] = rpt_fire;
        for (int i = NUM_RPT; i < NUM_BTN; i++) fire[i] = press[i] & ~bus.pause;
    end

    // registered command pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cmd_q <= '0;
        else        cmd_q <= fire;
    end

    assign bus.move_left  = cmd_q[B_LEFT];
    assign bus.move_right = cmd_q[B_RIGHT];
    assign bus.move_down  = cmd_q[B_DOWN];
    assign bus.rotate     = cmd_q[B_ROT];
`ifdef TETRIS_INPUT_HARD_DROP_EN
    assign bus.hard_drop  = cmd_q[4];
    assign grav_clr       = fire[B_DOWN] | fire[4];
`else
    assign grav_clr       = fire[B_DOWN];
`endif

    // gravity period with saturating subtract and floor; level 15 * step fits 28 bits
    always_comb begin
        level_prod = 28'(bus.level) * STEP_W;
        period_raw = (level_prod >= BASE_W) ? 28'd0 : (BASE_W - level_prod);
        period     = (period_raw < MIN_W) ? MIN_W : period_raw;
    end

    // gravity counter; >= catches a shorter period after a level change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grav_cnt <= '0;
            tick_q   <= 1'b0;
        end else if (bus.pause) begin
            tick_q <= 1'b0;
        end else if (grav_clr) begin
            grav_cnt <= '0;
            tick_q   <= 1'b0;
        end else if ({4'd0, grav_cnt} >= (period - 28'd1)) begin
            grav_cnt <= '0;
            tick_q   <= 1'b1;
        end else begin
            grav_cnt <= grav_cnt + 24'd1;
            tick_q   <= 1'b0;
        end
    end

    assign bus.tick = tick_q;
endmodule
